// File: rtl/spi_slave_rx_pkg.sv
// Shared definitions for the SPI receive slave: FSM encoding and parameter defaults.
package spi_slave_rx_pkg;

    localparam int unsigned DATA_W_DEF      = 8;
    localparam int unsigned SYNC_STAGES_DEF = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for one asynchronous pin, with registered rise/fall pulses
// derived from the last stage and one further registered copy.
module spi_sync_edge #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic init,
    input  logic din,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] stages;
    logic                   last;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stages <= {SYNC_STAGES{init}};
            last   <= init;
            rise   <= 1'b0;
            fall   <= 1'b0;
        end else begin
            stages[0] <= din;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                stages[i] <= stages[i-1];
            end
            last <= stages[SYNC_STAGES-1];
            rise <= stages[SYNC_STAGES-1] & ~last;
            fall <= ~stages[SYNC_STAGES-1] & last;
        end
    end

endmodule

// File: rtl/spi_slave_rx.sv
// SPI slave receiver, all four CPOL/CPHA modes, oversampled on clk; receives MSB-first
// words into rx_data with a valid/ack handshake and shifts a reply word out on miso.
module spi_slave_rx
    import spi_slave_rx_pkg::*;
#(
    parameter int unsigned DATA_W      = DATA_W_DEF,
    parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              polarity,
    input  logic              phase,
    input  logic              spi_clk,
    input  logic              cs,
    input  logic              mosi,
    output logic              miso,
    input  logic [DATA_W-1:0] tx_data,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ack,
    output logic              rx_overrun,
    output logic              frame_err,
    output logic              busy
);

    localparam int unsigned       CNT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(DATA_W - 1);

    state_t state, state_next;

    logic                   clk_rise, clk_fall, cs_rise, cs_fall;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic                   mosi_s;
    logic [CNT_W-1:0]       bit_cnt;
    logic [DATA_W-2:0]      rx_shift;
    logic [DATA_W-1:0]      tx_shift;
    logic [DATA_W-1:0]      rx_word;
    logic                   start, stop, abort;
    logic                   sample, shift_edge, word_done;

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_clk (
        .clk   (clk),
        .reset (reset),
        .init  (polarity),
        .din   (spi_clk),
        .rise  (clk_rise),
        .fall  (clk_fall)
    );

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_cs (
        .clk   (clk),
        .reset (reset),
        .init  (1'b1),
        .din   (cs),
        .rise  (cs_rise),
        .fall  (cs_fall)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mosi_sync <= '1;
        end else begin
            mosi_sync[0] <= mosi;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                mosi_sync[i] <= mosi_sync[i-1];
            end
        end
    end

    assign mosi_s = mosi_sync[SYNC_STAGES-1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        start      = 1'b0;
        stop       = 1'b0;
        abort      = 1'b0;
        case (state)
            IDLE: begin
                if (cs_fall) begin
                    state_next = SHIFT;
                    start      = 1'b1;
                end
            end
            SHIFT: begin
                if (cs_rise) begin
                    state_next = IDLE;
                    stop       = 1'b1;
                    abort      = (bit_cnt != '0);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // cs deassertion takes priority over any spi_clk edge landing in the same cycle
    assign sample     = (state == SHIFT) && !cs_rise && ((polarity == phase) ? clk_rise : clk_fall);
    assign shift_edge = (state == SHIFT) && !cs_rise && ((polarity == phase) ? clk_fall : clk_rise);
    assign word_done  = sample && (bit_cnt == LAST_BIT);
    assign rx_word    = {rx_shift, mosi_s};
    assign busy       = (state == SHIFT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            miso      <= 1'b1;
            bit_cnt   <= '0;
            rx_shift  <= '0;
            tx_shift  <= '0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= abort;
            if (start) begin
                bit_cnt <= '0;
                // CPHA=0 puts the MSB on miso now, so the register keeps only the bits still owed
                if (phase) begin
                    tx_shift <= tx_data;
                    miso     <= 1'b1;
                end else begin
                    tx_shift <= {tx_data[DATA_W-2:0], 1'b0};
                    miso     <= tx_data[DATA_W-1];
                end
            end else if (stop) begin
                bit_cnt <= '0;
                miso    <= 1'b1;
            end else if (sample) begin
                rx_shift <= rx_word[DATA_W-2:0];
                if (word_done) begin
                    bit_cnt  <= '0;
                    tx_shift <= tx_data;
                end else begin
                    bit_cnt <= bit_cnt + 1'b1;
                end
            end else if (shift_edge) begin
                miso     <= tx_shift[DATA_W-1];
                tx_shift <= {tx_shift[DATA_W-2:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            rx_overrun <= 1'b0;
        end else begin
            if (start) begin
                rx_overrun <= 1'b0;
            end
            if (word_done) begin
                if (!rx_valid || rx_ack) begin
                    rx_data  <= rx_word;
                    rx_valid <= 1'b1;
                end else begin
                    rx_overrun <= 1'b1;
                end
            end else if (rx_ack) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_spi_slave_rx.sv
// Directed bench for spi_slave_rx: SPI master driven from negedges with 2-clk spi_clk levels.
module tb_spi_slave_rx;

    logic       clk = 1'b0;
    logic       reset;
    logic       polarity, phase, spi_clk, cs, mosi, miso;
    logic [7:0] tx_data, rx_data;
    logic       rx_valid, rx_ack, rx_overrun, frame_err, busy;

    int checks = 0;
    int errors = 0;
    int fe_cnt = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (frame_err === 1'b1) fe_cnt++;
    end

    spi_slave_rx #(.DATA_W(8), .SYNC_STAGES(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .polarity   (polarity),
        .phase      (phase),
        .spi_clk    (spi_clk),
        .cs         (cs),
        .mosi       (mosi),
        .miso       (miso),
        .tx_data    (tx_data),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ack     (rx_ack),
        .rx_overrun (rx_overrun),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset(input logic pol, input logic pha);
        polarity = pol;
        phase    = pha;
        spi_clk  = pol;
        cs       = 1'b1;
        mosi     = 1'b1;
        rx_ack   = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(2);
    endtask

    // Master side: miso is captured 4 clk after the edge that presented each bit
    task automatic spi_bits(input logic [7:0] data, input int nbits, output logic [7:0] mbits);
        mbits = '0;
        for (int i = 0; i < nbits; i++) begin
            if (!phase) begin
                mosi = data[7-i];
                tick(2);
                spi_clk = ~polarity;
                tick(2);
                mbits[7-i] = miso;
                spi_clk = polarity;
            end else begin
                spi_clk = ~polarity;
                mosi = data[7-i];
                tick(2);
                spi_clk = polarity;
                tick(2);
                mbits[7-i] = miso;
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        do_reset(1'b0, 1'b0);
        checks++; if (miso !== 1'b1)        begin errors++; $display("FAIL reset_miso: got %b expected 1", miso); end
        checks++; if (rx_data !== 8'h00)    begin errors++; $display("FAIL reset_rx_data: got %h expected 00", rx_data); end
        checks++; if (rx_valid !== 1'b0)    begin errors++; $display("FAIL reset_rx_valid: got %b expected 0", rx_valid); end
        checks++; if (rx_overrun !== 1'b0)  begin errors++; $display("FAIL reset_rx_overrun: got %b expected 0", rx_overrun); end
        checks++; if (frame_err !== 1'b0)   begin errors++; $display("FAIL reset_frame_err: got %b expected 0", frame_err); end
        checks++; if (busy !== 1'b0)        begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    endtask

    task automatic test_mode00;
        logic [7:0] mb;
        int fe0;
        do_reset(1'b0, 1'b0);
        fe0 = fe_cnt;
        tx_data = 8'h3C;
        cs = 1'b0;
        tick(4);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL m00_busy: got %b expected 1", busy); end
        spi_bits(8'hA5, 7, mb);
        mosi = 1'b1;
        tick(2);
        spi_clk = 1'b1;
        tick(2);
        mb[0] = miso;
        tick(1);
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL m00_valid_early: got %b expected 0", rx_valid); end
        tick(1);
        checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL m00_valid_latency: got %b expected 1", rx_valid); end
        spi_clk = 1'b0;
        checks++; if (rx_data !== 8'hA5) begin errors++; $display("FAIL m00_rx_data: got %h expected a5", rx_data); end
        checks++; if (mb !== 8'h3C)      begin errors++; $display("FAIL m00_miso_bits: got %h expected 3c", mb); end
        tick(4);
        cs = 1'b1;
        tick(6);
        checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL m00_busy_end: got %b expected 0", busy); end
        checks++; if (miso !== 1'b1)     begin errors++; $display("FAIL m00_miso_idle: got %b expected 1", miso); end
        checks++; if (fe_cnt !== fe0)    begin errors++; $display("FAIL m00_no_frame_err: got %0d pulses expected 0", fe_cnt - fe0); end
    endtask

    task automatic test_modes;
        logic [7:0] mb;
        logic [1:0] mode;
        int fe0;
        for (int m = 1; m < 4; m++) begin
            mode = m[1:0];
            do_reset(mode[1], mode[0]);
            fe0 = fe_cnt;
            tx_data = 8'hC3;
            cs = 1'b0;
            tick(4);
            spi_bits(8'h81, 8, mb);
            tick(4);
            checks++; if (rx_data !== 8'h81) begin errors++; $display("FAIL mode%b_rx_data: got %h expected 81", mode, rx_data); end
            checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL mode%b_rx_valid: got %b expected 1", mode, rx_valid); end
            checks++; if (mb !== 8'hC3)      begin errors++; $display("FAIL mode%b_miso_bits: got %h expected c3", mode, mb); end
            cs = 1'b1;
            tick(6);
            checks++; if (fe_cnt !== fe0)    begin errors++; $display("FAIL mode%b_no_frame_err: got %0d pulses expected 0", mode, fe_cnt - fe0); end
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] mb;
        do_reset(1'b0, 1'b0);
        tx_data = 8'h00;
        cs = 1'b0;
        tick(4);
        spi_bits(8'h12, 8, mb);
        tick(4);
        checks++; if (rx_data !== 8'h12) begin errors++; $display("FAIL b2b_first: got %h expected 12", rx_data); end
        rx_ack = 1'b1;
        tick(1);
        rx_ack = 1'b0;
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL b2b_ack_clear: got %b expected 0", rx_valid); end
        spi_bits(8'h34, 8, mb);
        tick(4);
        checks++; if (rx_data !== 8'h34)    begin errors++; $display("FAIL b2b_second: got %h expected 34", rx_data); end
        checks++; if (rx_valid !== 1'b1)    begin errors++; $display("FAIL b2b_valid: got %b expected 1", rx_valid); end
        checks++; if (rx_overrun !== 1'b0)  begin errors++; $display("FAIL b2b_overrun: got %b expected 0", rx_overrun); end
        cs = 1'b1;
        tick(6);
    endtask

    task automatic test_overrun;
        logic [7:0] mb;
        do_reset(1'b0, 1'b0);
        tx_data = 8'h00;
        cs = 1'b0;
        tick(4);
        spi_bits(8'h55, 8, mb);
        tick(4);
        spi_bits(8'hAA, 8, mb);
        tick(4);
        checks++; if (rx_data !== 8'h55)   begin errors++; $display("FAIL ovr_rx_data: got %h expected 55", rx_data); end
        checks++; if (rx_overrun !== 1'b1) begin errors++; $display("FAIL ovr_set: got %b expected 1", rx_overrun); end
        cs = 1'b1;
        tick(6);
        checks++; if (rx_overrun !== 1'b1) begin errors++; $display("FAIL ovr_sticky: got %b expected 1", rx_overrun); end
        cs = 1'b0;
        tick(4);
        checks++; if (rx_overrun !== 1'b0) begin errors++; $display("FAIL ovr_clear: got %b expected 0", rx_overrun); end
        cs = 1'b1;
        tick(6);
    endtask

    task automatic test_frame_err;
        logic [7:0] mb;
        int fe0;
        int width;
        do_reset(1'b0, 1'b0);
        fe0 = fe_cnt;
        width = 0;
        tx_data = 8'h00;
        cs = 1'b0;
        tick(4);
        spi_bits(8'hFF, 5, mb);
        tick(2);
        cs = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick(1);
            if (frame_err === 1'b1) width++;
        end
        checks++; if (width !== 1)         begin errors++; $display("FAIL ferr_width: got %0d cycles expected 1", width); end
        checks++; if (rx_valid !== 1'b0)   begin errors++; $display("FAIL ferr_rx_valid: got %b expected 0", rx_valid); end
        checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL ferr_busy: got %b expected 0", busy); end
        cs = 1'b0;
        tick(4);
        spi_bits(8'hF0, 8, mb);
        tick(4);
        checks++; if (rx_data !== 8'hF0)   begin errors++; $display("FAIL ferr_next_byte: got %h expected f0", rx_data); end
        checks++; if (rx_valid !== 1'b1)   begin errors++; $display("FAIL ferr_next_valid: got %b expected 1", rx_valid); end
        cs = 1'b1;
        tick(6);
        checks++; if (fe_cnt - fe0 !== 1)  begin errors++; $display("FAIL ferr_total: got %0d pulses expected 1", fe_cnt - fe0); end
    endtask

    task automatic test_reset_mid;
        logic [7:0] mb;
        int fe0;
        do_reset(1'b0, 1'b0);
        tx_data = 8'h00;
        cs = 1'b0;
        tick(4);
        spi_bits(8'h5A, 8, mb);
        tick(4);
        spi_bits(8'hE0, 3, mb);
        fe0 = fe_cnt;
        #1 reset = 1'b1;
        #1;
        checks++; if (miso !== 1'b1)       begin errors++; $display("FAIL rmid_miso: got %b expected 1", miso); end
        checks++; if (rx_data !== 8'h00)   begin errors++; $display("FAIL rmid_rx_data: got %h expected 00", rx_data); end
        checks++; if (rx_valid !== 1'b0)   begin errors++; $display("FAIL rmid_rx_valid: got %b expected 0", rx_valid); end
        checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL rmid_busy: got %b expected 0", busy); end
        checks++; if (frame_err !== 1'b0)  begin errors++; $display("FAIL rmid_frame_err: got %b expected 0", frame_err); end
        cs = 1'b1;
        spi_clk = 1'b0;
        mosi = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(6);
        checks++; if (fe_cnt !== fe0)      begin errors++; $display("FAIL rmid_no_ferr: got %0d pulses expected 0", fe_cnt - fe0); end
        cs = 1'b0;
        tick(4);
        spi_bits(8'h0F, 8, mb);
        tick(4);
        checks++; if (rx_data !== 8'h0F)   begin errors++; $display("FAIL rmid_next_byte: got %h expected 0f", rx_data); end
        checks++; if (rx_valid !== 1'b1)   begin errors++; $display("FAIL rmid_next_valid: got %b expected 1", rx_valid); end
        cs = 1'b1;
        tick(6);
    endtask

    initial begin
        reset    = 1'b1;
        polarity = 1'b0;
        phase    = 1'b0;
        spi_clk  = 1'b0;
        cs       = 1'b1;
        mosi     = 1'b1;
        rx_ack   = 1'b0;
        tx_data  = 8'h00;
        test_reset();
        test_mode00();
        test_modes();
        test_back_to_back();
        test_overrun();
        test_frame_err();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_slave_rx.md
SPI_SLAVE_RX -- requirements
Module: spi_slave_rx

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, meaning bits per SPI word.
REQ-002 The block SHALL have parameter SYNC_STAGES, default 2, meaning synchroniser flops per SPI input pin.
REQ-003 The block SHALL have port clk  input  1  system clock; all logic is on its rising edge; it is the only clock.
REQ-004 The block SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 The block SHALL have port polarity  input  1  SPI CPOL, static during a frame.
REQ-006 The block SHALL have port phase  input  1  SPI CPHA, static during a frame.
REQ-007 The block SHALL have port spi_clk  input  1  serial clock from the master; asynchronous to clk.
REQ-008 The block SHALL have port cs  input  1  chip select, active low; asynchronous.
REQ-009 The block SHALL have port mosi  input  1  serial data from the master, MSB first.
REQ-010 The block SHALL have port miso  output  1  serial reply to the master, MSB first.
REQ-011 The block SHALL have port tx_data  input  DATA_W  reply word, loaded at frame start and at each word boundary.
REQ-012 The block SHALL have port rx_data  output  DATA_W  last complete received word.
REQ-013 The block SHALL have port rx_valid  output  1  level; high while rx_data holds an unacknowledged word.
REQ-014 The block SHALL have port rx_ack  input  1  single-cycle pulse from the consumer that clears rx_valid.
REQ-015 The block SHALL have port rx_overrun  output  1  sticky; a word completed while rx_valid was high.
REQ-016 The block SHALL have port frame_err  output  1  one-cycle pulse; cs deasserted mid-word.
REQ-017 The block SHALL have port busy  output  1  high while the FSM is in SHIFT.

Function
REQ-018 spi_clk, cs and mosi SHALL each pass through SYNC_STAGES flops before use; an edge SHALL be detected by comparing the last stage with one further registered copy.
REQ-019 The sample edge SHALL be rising when polarity==phase and falling otherwise; the shift edge SHALL be the opposite edge.
REQ-020 Correct operation SHALL require each spi_clk level and each cs level to be held for at least 2 clk cycles.
REQ-021 The FSM SHALL have two states: IDLE (synced cs high) and SHIFT (synced cs low).
REQ-022 On a synced cs falling edge the FSM SHALL go from IDLE to SHIFT, load tx_data into tx_shift, clear bit_cnt and, when phase=0, drive miso = tx_data[DATA_W-1] in the same cycle.
REQ-023 On each sample edge in SHIFT the block SHALL shift synced mosi into the LSB of rx_shift and increment bit_cnt.
REQ-024 On each shift edge in SHIFT, miso SHALL present the next tx_shift bit.
REQ-025 When phase=1, the first shift edge SHALL present tx_data[DATA_W-1].
REQ-026 When the DATA_W-th bit is sampled, the block SHALL write the word to rx_data, set rx_valid, wrap bit_cnt to 0 and reload tx_shift from tx_data, so multi-word frames continue without gaps.
REQ-027 rx_valid SHALL rise exactly SYNC_STAGES+2 clk edges after the pin-level sample edge.
REQ-028 rx_ack with rx_valid high SHALL clear rx_valid on the next edge.
REQ-029 If a word completes in the same cycle as rx_ack, the block SHALL load the new word, keep rx_valid high and leave rx_overrun unchanged.
REQ-030 If a word completes while rx_valid is high and rx_ack is low, the block SHALL drop the new word, leave rx_data unchanged and set rx_overrun.
REQ-031 rx_overrun SHALL clear only on reset or on the next synced cs falling edge.
REQ-032 A synced cs rising edge with bit_cnt != 0 SHALL discard the partial word, pulse frame_err for one cycle and return the FSM to IDLE.
REQ-033 A synced cs rising edge with bit_cnt == 0 SHALL return the FSM to IDLE with no error.
REQ-034 In IDLE, miso SHALL be 1 and spi_clk edges SHALL be ignored.

Reset
REQ-035 When reset is asserted, the block SHALL immediately force: state=IDLE, miso=1, rx_data=0, rx_valid=0, rx_overrun=0, frame_err=0, busy=0, bit_cnt=0, shift registers=0, and all synchroniser flops to their idle values (cs=1, spi_clk=polarity, mosi=1).
REQ-036 Reset mid-frame SHALL discard the word in progress without pulsing frame_err; after release the block SHALL wait for a fresh cs falling edge.

Structure
REQ-037 The shared package SHALL hold the FSM state encoding (IDLE, SHIFT), the DATA_W default and the SYNC_STAGES default.
REQ-038 The block SHALL use one sub-module, spi_sync_edge: a SYNC_STAGES synchroniser with rise/fall pulse outputs, instantiated once each for spi_clk and cs; mosi SHALL use the synchroniser only.

Verification
REQ-039 Mode 00, spi_clk period 4 clk, mosi byte 0xA5, tx_data=0x3C -> rx_data=0xA5, rx_valid high, miso bits 0,0,1,1,1,1,0,0.
REQ-040 Modes 01, 10 and 11, each sending 0x81 -> rx_data=0x81 in every mode, and frame_err never pulses.
REQ-041 Two-byte frame 0x12, 0x34, with rx_ack after the first -> second rx_data=0x34, rx_overrun=0.
REQ-042 Two-byte frame 0x55, 0xAA with no rx_ack -> rx_data=0x55, rx_overrun=1, then a new cs falling edge clears rx_overrun.
REQ-043 cs raised after 5 bits -> frame_err one-cycle pulse, rx_valid stays 0, and the next full byte 0xF0 is received correctly.
REQ-044 reset asserted after 3 bits -> all outputs take their REQ-035 values immediately, and the next frame with 0x0F yields rx_data=0x0F.
